uart_bus_ctrl: RTL and testbench

Memory-mapped UART controller that sits between the CPU data bus and the existing 16×-baud UART transmitter and receiver. It buffers received bytes in an RX FIFO and holds one outgoing byte. It drives the transmitter through a level handshake on `tx_en`/`tx_status`. It exposes data, status and control registers over a 2-bit register address.

---
 rtl/uart_bus_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_uart_bus_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_ctrl.sv
// uart_bus_ctrl
//   Memory-mapped UART controller between the CPU data bus and an existing
//   16x-baud UART transmitter/receiver. Received bytes go into an RX FIFO.
//   One outgoing byte is held and handed to the transmitter through a level
//   handshake on tx_en / tx_status.
//
// Parameters
//   PTR_W     RX FIFO pointer width, depth = 2**PTR_W (PTR_W >= 1)
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous reset, active low
//   addr[1:0]  in   register select: 0 TXDATA, 1 RXDATA, 2 STATUS, 3 CTRL
//   wr, rd     in   one-cycle write / read strobes
//   wdata[7:0] in   write data
//   rdata[7:0] out  registered read data, holds until the next read
//   rx_data    in   received byte, stable while rx_status is high
//   rx_status  in   receiver byte-valid level, rising edge = new byte
//   tx_status  in   transmitter idle level (1 = idle)
//   tx_data    out  byte presented to the transmitter
//   tx_en      out  transmit request level
//   irq        out  interrupt request
//
// Build option
//   UART_IRQ_EN  adds the CTRL register (bit0 rx_ie, bit1 tx_ie) and a
//                registered irq; without it CTRL reads 0 and irq is 0.
//
// TX FSM
//   state | meaning
//   IDLE  | waiting for an occupied holding register and an idle transmitter
//   REQ   | tx_en high, waiting for the transmitter to go busy
//   BUSY  | holding register free again, waiting for the transmitter to idle
module uart_bus_ctrl #(
  parameter int PTR_W = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] addr,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  input  logic [7:0] rx_data,
  input  logic       rx_status,
  input  logic       tx_status,
  output logic [7:0] tx_data,
  output logic       tx_en,
  output logic       irq
);

  localparam int DEPTH = 2 ** PTR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2
  } tx_state_t;

  logic rx_s1, rxs, rxs_q;
  logic tx_s1, txs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1 <= 1'b0;
      rxs   <= 1'b0;
      rxs_q <= 1'b0;
      tx_s1 <= 1'b0;
      txs   <= 1'b0;
    end else begin
      rx_s1 <= rx_status;
      rxs   <= rx_s1;
      rxs_q <= rxs;
      tx_s1 <= tx_status;
      txs   <= tx_s1;
    end
  end

  // RX FIFO
  logic [7:0]     mem [DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic           rx_empty, rx_full, rx_rise;
  logic           pop, push, ovr_set;
  logic           overrun;

  assign rx_empty = (wr_ptr == rd_ptr);
  assign rx_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign rx_rise  = rxs & ~rxs_q;
  assign pop      = rd && (addr == 2'd1) && !rx_empty;
  // A pop in the same cycle frees the slot being written, so a full FIFO
  // still accepts the byte; the read sees the old contents of that slot.
  assign push     = rx_rise && (!rx_full || pop);
  assign ovr_set  = rx_rise && rx_full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= rx_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Set wins over the clear-on-read of STATUS.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      overrun <= 1'b0;
    else if (ovr_set)                overrun <= 1'b1;
    else if (rd && (addr == 2'd2))   overrun <= 1'b0;
  end

  // TX holding register and FSM
  tx_state_t  state, state_nxt;
  logic       hold_full;
  logic [7:0] hold_data;
  logic       tx_load, hold_free, tx_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hold_full && txs) state_nxt = REQ;
      REQ:     if (!txs)             state_nxt = BUSY;
      BUSY:    if (txs)              state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_en     = 1'b0;
    tx_load   = 1'b0;
    hold_free = 1'b0;
    case (state)
      IDLE:    tx_load = hold_full && txs;
      REQ: begin
        tx_en     = 1'b1;
        hold_free = !txs;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_full <= 1'b0;
      hold_data <= 8'h00;
    end else if (hold_free) begin
      hold_full <= 1'b0;
    end else if (wr && (addr == 2'd0) && !hold_full) begin
      hold_full <= 1'b1;
      hold_data <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       tx_data <= 8'h00;
    else if (tx_load) tx_data <= hold_data;
  end

  assign tx_busy = hold_full || (state != IDLE);

  // CTRL and interrupt
  logic [7:0] ctrl_val;

`ifdef UART_IRQ_EN
  logic rx_ie, tx_ie;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_ie <= 1'b0;
      tx_ie <= 1'b0;
      irq   <= 1'b0;
    end else begin
      if (wr && (addr == 2'd3)) begin
        rx_ie <= wdata[0];
        tx_ie <= wdata[1];
      end
      irq <= (rx_ie && !rx_empty) || (tx_ie && !tx_busy);
    end
  end

  assign ctrl_val = {6'b0, tx_ie, rx_ie};
`else
  assign ctrl_val = 8'h00;
  assign irq      = 1'b0;
`endif

  // Read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= 8'h00;
    end else if (rd) begin
      case (addr)
        2'd1:    rdata <= rx_empty ? 8'h00 : mem[rd_ptr[PTR_W-1:0]];
        2'd2:    rdata <= {4'b0, overrun, tx_busy, rx_full, !rx_empty};
        2'd3:    rdata <= ctrl_val;
        default: rdata <= 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_ctrl.sv
module tb_uart_bus_ctrl;

  localparam int DEPTH = 8;

  logic       clk;
  logic       reset;
  logic [1:0] addr;
  logic       wr, rd;
  logic [7:0] wdata, rdata;
  logic [7:0] rx_data;
  logic       rx_status, tx_status;
  logic [7:0] tx_data;
  logic       tx_en, irq;

  uart_bus_ctrl #(.PTR_W(3)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wr(wr), .rd(rd),
    .wdata(wdata), .rdata(rdata), .rx_data(rx_data), .rx_status(rx_status),
    .tx_status(tx_status), .tx_data(tx_data), .tx_en(tx_en), .irq(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0] rxq[$];
  logic [7:0] sent[$];
  logic [7:0] exp_tx[$];
  logic       ovr_m = 1'b0;
  logic [1:0] ctrl_m = 2'b00;
  int         tx_checked = 0;
  int         req_len = 2;
  int         busy_len = 20;

  function automatic logic [7:0] model_status();
    return {4'b0, ovr_m, 1'b0, rxq.size() == DEPTH, rxq.size() != 0};
  endfunction

  // Transmitter model: accepts a byte when tx_en is seen while idle, goes busy,
  // and returns to idle some cycles after the request is withdrawn.
  initial begin
    tx_status = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_en && tx_status) begin
        sent.push_back(tx_data);
        repeat (req_len) @(negedge clk);
        tx_status = 1'b0;
        for (int i = 0; i < 60 && tx_en; i++) @(negedge clk);
        if (tx_en) check("tx_en_drop", tx_en, 1'b0);
        repeat (busy_len) @(negedge clk);
        tx_status = 1'b1;
      end
    end
  end

  task automatic bus(input logic [1:0] a, input logic w, input logic r,
                     input logic [7:0] d, output logic [7:0] q);
    @(negedge clk);
    addr = a; wr = w; rd = r; wdata = d;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0;
    q = rdata;
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_status = 1'b1;
    repeat (2) @(negedge clk);
    rx_status = 1'b0;
    repeat (4) @(negedge clk);
    if (rxq.size() < DEPTH) rxq.push_back(b);
    else                    ovr_m = 1'b1;
  endtask

  task automatic read_rx(output logic [7:0] v);
    logic [7:0] d, e;
    bus(2'd1, 1'b0, 1'b1, 8'h00, d);
    e = (rxq.size() != 0) ? rxq.pop_front() : 8'h00;
    check("rxdata", d, e);
    v = e;
  endtask

  task automatic read_status(input logic w, input logic [7:0] wd);
    logic [7:0] d, e;
    bus(2'd2, w, 1'b1, wd, d);
    e = model_status();
    ovr_m = 1'b0;
    check("status", d, e);
  endtask

  task automatic wait_tx_done();
    int i;
    i = 0;
    while (i < 400 && !(sent.size() >= exp_tx.size() && tx_status && !tx_en)) begin
      @(negedge clk);
      i++;
    end
    repeat (4) @(negedge clk);
    check("tx_count", sent.size(), exp_tx.size());
    for (int k = tx_checked; k < sent.size() && k < exp_tx.size(); k++)
      check("tx_byte", sent[k], exp_tx[k]);
    tx_checked = sent.size();
  endtask

  logic [7:0] d, v, b;
  int         op;

  initial begin
    reset = 1'b0; addr = 2'd0; wr = 1'b0; rd = 1'b0; wdata = 8'h00;
    rx_data = 8'h00; rx_status = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rdata", rdata, 8'h00);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_tx_en", tx_en, 1'b0);
    check("rst_irq", irq, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    read_status(1'b0, 8'h00);

    // RX burst
    push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
    read_status(1'b0, 8'h00);
    repeat (4) read_rx(v);
    read_status(1'b0, 8'h00);

    // Overrun: nine bytes into eight slots
    for (int i = 0; i < 9; i++) push_byte(i[7:0]);
    read_status(1'b0, 8'h00);
    read_status(1'b0, 8'h00);

    // Push landing on the same edge as a pop while full
    @(negedge clk);
    rx_data = 8'h09; rx_status = 1'b1;
    @(negedge clk);
    @(negedge clk);
    addr = 2'd1; rd = 1'b1;
    @(posedge clk);
    #1;
    rd = 1'b0;
    d = rdata;
    v = rxq.pop_front();
    rxq.push_back(8'h09);
    check("coincident_pop", d, v);
    @(negedge clk);
    rx_status = 1'b0;
    repeat (4) @(negedge clk);
    read_status(1'b0, 8'h00);
    repeat (8) read_rx(v);
    read_status(1'b0, 8'h00);

    // TX handshake
    req_len = 2; busy_len = 20;
    bus(2'd0, 1'b1, 1'b0, 8'h5A, d);
    exp_tx.push_back(8'h5A);
    check("tx_en_at_n", tx_en, 1'b0);
    @(posedge clk);
    #1;
    check("tx_en_at_n1", tx_en, 1'b1);
    check("tx_data_at_n1", tx_data, 8'h5A);
    for (int i = 0; i < 60 && tx_en; i++) @(negedge clk);
    check("tx_en_fall", tx_en, 1'b0);
    bus(2'd2, 1'b0, 1'b1, 8'h00, d);
    check("status_busy", d, 8'h04);
    bus(2'd0, 1'b1, 1'b0, 8'hA5, d);
    exp_tx.push_back(8'hA5);
    bus(2'd0, 1'b1, 1'b0, 8'hC3, d);
    bus(2'd2, 1'b0, 1'b1, 8'h00, d);
    check("status_hold", d, 8'h04);
    wait_tx_done();
    repeat (20) @(negedge clk);
    check("tx_no_extra", sent.size(), 2);
    bus(2'd0, 1'b0, 1'b1, 8'h00, d);
    check("txdata_read", d, 8'h00);

    // Echo loop
    busy_len = 3;
    push_byte(8'h00); push_byte(8'h7F); push_byte(8'h80); push_byte(8'hFF);
    for (int i = 0; i < 4; i++) begin
      read_rx(v);
      bus(2'd0, 1'b1, 1'b0, v, d);
      exp_tx.push_back(v);
      wait_tx_done();
    end

`ifdef UART_IRQ_EN
    bus(2'd3, 1'b1, 1'b0, 8'h01, d);
    bus(2'd3, 1'b0, 1'b1, 8'h00, d);
    check("ctrl_read", d, 8'h01);
    repeat (2) @(negedge clk);
    check("irq_rx_empty", irq, 1'b0);
    push_byte(8'h66);
    check("irq_rx_set", irq, 1'b1);
    read_rx(v);
    repeat (2) @(negedge clk);
    check("irq_rx_clr", irq, 1'b0);
    bus(2'd3, 1'b1, 1'b0, 8'h02, d);
    repeat (2) @(negedge clk);
    check("irq_tx_idle", irq, 1'b1);
    bus(2'd0, 1'b1, 1'b0, 8'h3C, d);
    exp_tx.push_back(8'h3C);
    @(posedge clk);
    #1;
    check("irq_tx_busy", irq, 1'b0);
    wait_tx_done();
    check("irq_tx_done", irq, 1'b1);
    ctrl_m = 2'($urandom_range(0, 3));
    bus(2'd3, 1'b1, 1'b0, {6'b0, ctrl_m}, d);
`else
    bus(2'd3, 1'b1, 1'b0, 8'hFF, d);
    bus(2'd3, 1'b0, 1'b1, 8'h00, d);
    check("ctrl_read", d, 8'h00);
    push_byte(8'h66);
    check("irq_off", irq, 1'b0);
    read_rx(v);
`endif

    // Randomized traffic against the model
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 5);
      case (op)
        0, 1: push_byte(8'($urandom_range(0, 255)));
        2:    read_rx(v);
        3:    read_status(1'b0, 8'h00);
        4: begin
          busy_len = $urandom_range(1, 5);
          req_len  = $urandom_range(1, 3);
          b = 8'($urandom_range(0, 255));
          bus(2'd0, 1'b1, 1'b0, b, d);
          exp_tx.push_back(b);
          wait_tx_done();
        end
        default: read_status(1'b1, 8'($urandom_range(0, 255)));
      endcase
      repeat (2) @(negedge clk);
`ifdef UART_IRQ_EN
      check("irq_rand", irq, (ctrl_m[0] && rxq.size() != 0) || ctrl_m[1]);
`else
      check("irq_rand", irq, 1'b0);
`endif
    end

    // Reset in the middle of a request
    req_len = 10; busy_len = 3;
    bus(2'd0, 1'b1, 1'b0, 8'h33, d);
    @(posedge clk);
    #1;
    check("mid_tx_en", tx_en, 1'b1);
    reset = 1'b0;
    #1;
    check("mid_rst_tx_en", tx_en, 1'b0);
    check("mid_rst_tx_data", tx_data, 8'h00);
    rxq.delete();
    ovr_m = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    read_status(1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
